// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: walks start/data/parity/stop using an oversampling edge counter and a bit counter.
// data_valid pulses 1+Prescale*(DATA_W+2+parity) cycles after start detect; no backpressure, frames run at line rate.
module uart_rx_fsm #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    VALID  = 3'd5
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  par_en_q;
  logic [PRESCALE_W-1:0] last_edge;
  logic [PRESCALE_W-1:0] samp_edge;
  logic                  at_last;
  logic                  last_data_bit;
  logic                  cur_active;
  logic                  next_active;

  assign last_edge     = Prescale - PRESCALE_W'(1);
  assign samp_edge     = (Prescale >> 1) + PRESCALE_W'(2);
  // >= rather than == so an out-of-range edge count still closes the bit instead of running on
  assign at_last       = (edge_cnt >= last_edge);
  assign last_data_bit = (bit_cnt >= BIT_CNT_W'(DATA_W));
  assign cur_active    = (state inside {START, DATA, PARITY, STOP});
  assign next_active   = (next_state inside {START, DATA, PARITY, STOP});

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!RX_IN) next_state = START;
      START:   if (at_last) next_state = strt_glitch ? IDLE : DATA;
      DATA:    if (at_last && last_data_bit) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (at_last) next_state = par_err ? IDLE : STOP;
      STOP:    if (at_last) next_state = stp_err ? IDLE : VALID;
      VALID:   next_state = RX_IN ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // Counters only run while staying inside a frame; entering START always begins at edge 0 of bit 0
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
    end else begin
      if (cur_active && next_active) begin
        if (at_last) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
        end else begin
          edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
      end else begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end
      if (!cur_active && next_state == START) begin
        par_en_q <= PAR_EN;
      end
    end
  end

  always_comb begin
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state)
      START: begin
        dat_samp_en = 1'b1;
        strt_chk_en = (edge_cnt >= samp_edge);
      end
      DATA: begin
        dat_samp_en = 1'b1;
        deser_en    = (edge_cnt == samp_edge);
      end
      PARITY: begin
        dat_samp_en = 1'b1;
        par_chk_en  = (edge_cnt >= samp_edge);
      end
      STOP: begin
        dat_samp_en = 1'b1;
        stp_chk_en  = (edge_cnt >= samp_edge);
      end
      VALID:   data_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
